// File: rtl/if_id_stage_reg_if.sv
// Bundles the fetch-side inputs, hazard controls and decode-side outputs of the
// IF/ID stage register; the master drives the inputs and the slave is the register.
interface if_id_stage_reg_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_i;
    logic [31:0]     instr_i;
    logic            instrReady_i;
    logic            bubble_i;
    logic            flush_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pcPlus4_o;
    logic [31:0]     instr_o;
    logic            valid_o;
    logic            pcWriteEn_o;
    logic            idExBubble_o;
    logic [1:0]      state_o;
    logic [31:0]     stallCount_o;

    modport master (
        output pc_i, instr_i, instrReady_i, bubble_i, flush_i,
        input  pc_o, pcPlus4_o, instr_o, valid_o, pcWriteEn_o, idExBubble_o,
               state_o, stallCount_o
    );

    modport slave (
        input  pc_i, instr_i, instrReady_i, bubble_i, flush_i,
        output pc_o, pcPlus4_o, instr_o, valid_o, pcWriteEn_o, idExBubble_o,
               state_o, stallCount_o
    );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with flush/stall/fetch-wait control for the RV32IM pipeline.
// Define STALL_COUNTER_EN to build the saturating stall-cycle counter; otherwise it reads 0.
module if_id_stage_reg #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic              clk,
    input logic              rst,
    if_id_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL      = 2'd1,
        FETCH_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcPlus4_q, pcPlus4_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    // Priority decode: flush beats a load-use bubble, which beats a missing fetch.
    always_comb begin
        pc_d      = pc_q;
        pcPlus4_d = pcPlus4_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        state_d   = state_q;
        if (bus.flush_i) begin
            pc_d      = bus.pc_i;
            pcPlus4_d = bus.pc_i + XLEN'(4);
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            state_d   = RUN;
        end else if (bus.bubble_i) begin
            state_d   = STALL;
        end else if (!bus.instrReady_i) begin
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            state_d   = FETCH_WAIT;
        end else begin
            pc_d      = bus.pc_i;
            pcPlus4_d = bus.pc_i + XLEN'(4);
            instr_d   = bus.instr_i;
            valid_d   = 1'b1;
            state_d   = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            pcPlus4_q <= XLEN'(4);
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            state_q   <= RUN;
        end else begin
            pc_q      <= pc_d;
            pcPlus4_q <= pcPlus4_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    // While reset is held the PC stays frozen and ID/EX sees a bubble.
    assign bus.pcWriteEn_o  = !rst && (bus.flush_i || (!bus.bubble_i && bus.instrReady_i));
    assign bus.idExBubble_o = rst || bus.flush_i || bus.bubble_i;

    assign bus.pc_o      = pc_q;
    assign bus.pcPlus4_o = pcPlus4_q;
    assign bus.instr_o   = instr_q;
    assign bus.valid_o   = valid_q;
    assign bus.state_o   = state_q;

`ifdef STALL_COUNTER_EN
    logic [31:0] stallCount_q;
    logic        stallCycle;

    assign stallCycle = !bus.flush_i && (bus.bubble_i || !bus.instrReady_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount_q <= '0;
        end else if (stallCycle && (stallCount_q != 32'hFFFF_FFFF)) begin
            stallCount_q <= stallCount_q + 32'd1;
        end
    end

    assign bus.stallCount_o = stallCount_q;
`else
    assign bus.stallCount_o = '0;
`endif
endmodule
